// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
//
// Purpose: FSM state encoding, access-size width and the word access code
//          used by mem_arbiter and mem_arb_timer.
// Ports:   none (package).

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int FUNCT3_W = 3;
    localparam logic [FUNCT3_W-1:0] FUNCT3_WORD = 3'b010;

    // Width of the grant wait counter; TIMEOUT must fit in it.
    localparam int WAIT_W = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - grant wait counter with timeout compare
//
// Purpose: counts grant cycles spent waiting for the memory and flags the
//          cycle in which the count would reach the timeout value.
// Ports:   clk      - clock
//          rstn     - synchronous active-low reset
//          clear    - zero the count (grant entry)
//          enable   - this is a waiting grant cycle
//          timeout  - compare value, 1..255
//          expired  - this waiting cycle is the one that reaches timeout

module mem_arb_timer
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              enable,
    input  logic [WAIT_W-1:0] timeout,
    output logic              expired
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WAIT_W'(1);
        end
    end

    // Expiry is flagged while the count is still one short, so the grant
    // lasts exactly `timeout` cycles before the FSM leaves it.
    assign expired = enable && (count == timeout - WAIT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter onto one memory port
//
// Purpose: arbitrates instruction-fetch and load/store requests onto a single
//          shared memory request port, with round-robin on conflict and a
//          grant timeout that completes the access with an error flag.
// Ports:   iClk, iRstN                    - clock, synchronous active-low reset
//          iIReq, iIAddr                  - fetch request and address
//          oIValid, oIRdata               - fetch completion pulse and data
//          iDReq, iDWe, iDAddr, iDWdata,
//          iDFunct3                       - load/store request fields
//          oDValid, oDRdata               - load/store completion and data
//          oErr                           - completion was a timeout
//          oMemReq, oMemWe, oMemAddr,
//          oMemWdata, oMemFunct3          - shared memory request
//          iMemReady, iMemRdata           - memory done and read data

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iIReq,
    input  logic [DATA_W-1:0]   iIAddr,
    output logic                oIValid,
    output logic [DATA_W-1:0]   oIRdata,
    input  logic                iDReq,
    input  logic                iDWe,
    input  logic [DATA_W-1:0]   iDAddr,
    input  logic [DATA_W-1:0]   iDWdata,
    input  logic [FUNCT3_W-1:0] iDFunct3,
    output logic                oDValid,
    output logic [DATA_W-1:0]   oDRdata,
    output logic                oErr,
    output logic                oMemReq,
    output logic                oMemWe,
    output logic [DATA_W-1:0]   oMemAddr,
    output logic [DATA_W-1:0]   oMemWdata,
    output logic [FUNCT3_W-1:0] oMemFunct3,
    input  logic                iMemReady,
    input  logic [DATA_W-1:0]   iMemRdata
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    arb_state_t state, state_next;

    // last_d doubles as "port of the transaction in flight": it is written on
    // every grant, so in DONE it names the port whose valid must pulse.
    logic                last_d;
    logic                we_q;
    logic                err_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [FUNCT3_W-1:0] funct3_q;
    logic [DATA_W-1:0]   irdata_q;
    logic [DATA_W-1:0]   drdata_q;

    logic grant_i, grant_d;
    logic tmr_clear, tmr_en, tmr_expired;
    logic in_gnt, done_ok, done_to;
    logic [DATA_W-1:0] cap_data;

    mem_arb_timer u_timer (
        .clk     (iClk),
        .rstn    (iRstN),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .timeout (TIMEOUT_CNT),
        .expired (tmr_expired)
    );

    assign in_gnt   = (state == GNT_I) || (state == GNT_D);
    assign done_ok  = in_gnt && iMemReady;
    assign done_to  = in_gnt && !iMemReady && tmr_expired;
    assign cap_data = done_ok ? iMemRdata : '0;

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        tmr_clear  = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (iIReq && iDReq) begin
                    grant_i = last_d;
                    grant_d = !last_d;
                end else begin
                    grant_i = iIReq;
                    grant_d = iDReq;
                end
                if (grant_i) state_next = GNT_I;
                if (grant_d) state_next = GNT_D;
                tmr_clear = grant_i || grant_d;
            end
            GNT_I, GNT_D: begin
                tmr_en = !iMemReady;
                if (done_ok || done_to) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                last_d   <= 1'b0;
                addr_q   <= iIAddr;
                we_q     <= 1'b0;
                wdata_q  <= '0;
                funct3_q <= FUNCT3_WORD;
            end
            if (grant_d) begin
                last_d   <= 1'b1;
                addr_q   <= iDAddr;
                we_q     <= iDWe;
                wdata_q  <= iDWdata;
                funct3_q <= iDFunct3;
            end
            if (done_ok || done_to) begin
                err_q <= done_to;
                // A completed store leaves oDRdata alone; a timed-out access
                // always reports zero data on its port.
                if (state == GNT_I) begin
                    irdata_q <= cap_data;
                end else if (done_to || !we_q) begin
                    drdata_q <= cap_data;
                end
            end
        end
    end

    assign oMemReq    = in_gnt;
    assign oMemWe     = we_q;
    assign oMemAddr   = addr_q;
    assign oMemWdata  = wdata_q;
    assign oMemFunct3 = funct3_q;
    assign oIValid    = (state == DONE) && !last_d;
    assign oDValid    = (state == DONE) && last_d;
    assign oErr       = (state == DONE) && err_q;
    assign oIRdata    = irdata_q;
    assign oDRdata    = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TO   = 7;
    localparam int TO_T = 4;

    logic iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic        rstn;
    logic        ireq, dreq, dwe, ready;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [2:0]  df3;
    logic        ivalid, dvalid, err, mreq, mwe;
    logic [31:0] irdata, drdata, maddr, mwdata;
    logic [2:0]  mf3;

    logic        t_dreq, t_ready;
    logic [31:0] t_daddr, t_rdata;
    logic        t_ivalid, t_dvalid, t_err, t_mreq, t_mwe;
    logic [31:0] t_irdata, t_drdata, t_maddr, t_mwdata;
    logic [2:0]  t_mf3;

    mem_arbiter #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .iClk(iClk), .iRstN(rstn),
        .iIReq(ireq), .iIAddr(iaddr), .oIValid(ivalid), .oIRdata(irdata),
        .iDReq(dreq), .iDWe(dwe), .iDAddr(daddr), .iDWdata(dwdata), .iDFunct3(df3),
        .oDValid(dvalid), .oDRdata(drdata), .oErr(err),
        .oMemReq(mreq), .oMemWe(mwe), .oMemAddr(maddr), .oMemWdata(mwdata),
        .oMemFunct3(mf3), .iMemReady(ready), .iMemRdata(mrdata)
    );

    mem_arbiter #(.DATA_W(32), .TIMEOUT(TO_T)) dut_to (
        .iClk(iClk), .iRstN(rstn),
        .iIReq(1'b0), .iIAddr(32'h0), .oIValid(t_ivalid), .oIRdata(t_irdata),
        .iDReq(t_dreq), .iDWe(1'b0), .iDAddr(t_daddr), .iDWdata(32'h0), .iDFunct3(3'b010),
        .oDValid(t_dvalid), .oDRdata(t_drdata), .oErr(t_err),
        .oMemReq(t_mreq), .oMemWe(t_mwe), .oMemAddr(t_maddr), .oMemWdata(t_mwdata),
        .oMemFunct3(t_mf3), .iMemReady(t_ready), .iMemRdata(t_rdata)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Transaction-level model of the main DUT: an access in flight, how long
    // it has waited, and a one-cycle completion report afterwards.
    bit          m_act, m_port_d, m_done, m_done_d, m_err, m_last_d, m_we;
    int          m_wait;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
    logic [2:0]  m_f3;

    initial begin
        forever begin
            @(posedge iClk);
            if (!rstn) begin
                m_act = 0; m_port_d = 0; m_done = 0; m_done_d = 0; m_err = 0;
                m_last_d = 0; m_we = 0; m_wait = 0;
                m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0; m_f3 = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_act) begin
                if (ready) begin
                    m_act = 0; m_done = 1; m_done_d = m_port_d; m_err = 0;
                    if (!m_port_d) m_irdata = mrdata;
                    else if (!m_we) m_drdata = mrdata;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_act = 0; m_done = 1; m_done_d = m_port_d; m_err = 1;
                        if (m_port_d) m_drdata = 0;
                        else m_irdata = 0;
                    end
                end
            end else if (ireq || dreq) begin
                m_port_d = dreq && (!ireq || !m_last_d);
                m_last_d = m_port_d;
                m_act    = 1;
                m_wait   = 0;
                m_addr   = m_port_d ? daddr : iaddr;
                m_we     = m_port_d ? dwe : 1'b0;
                m_wdata  = dwdata;
                m_f3     = m_port_d ? df3 : 3'b010;
            end
        end
    end

    initial begin
        forever begin
            @(negedge iClk);
            if (cmp_en) begin
                check1("memreq", mreq, m_act);
                check1("ivalid", ivalid, m_done && !m_done_d);
                check1("dvalid", dvalid, m_done && m_done_d);
                if (m_done) check1("err", err, m_err);
                check32("irdata", irdata, m_irdata);
                check32("drdata", drdata, m_drdata);
                if (m_act) begin
                    check32("memaddr", maddr, m_addr);
                    check1("memwe", mwe, m_we);
                    check32("memfunct3", {29'b0, mf3}, {29'b0, m_f3});
                    if (m_port_d) check32("memwdata", mwdata, m_wdata);
                end
            end
        end
    end

    bit i_pend, d_pend;

    initial begin
        rstn = 0; ireq = 0; dreq = 0; dwe = 0; ready = 0;
        iaddr = 0; daddr = 0; dwdata = 0; mrdata = 0; df3 = 0;
        t_dreq = 0; t_ready = 0; t_daddr = 0; t_rdata = 0;
        repeat (3) step();
        cmp_en = 1;

        check1("rst_memreq", mreq, 1'b0);
        check1("rst_ivalid", ivalid, 1'b0);
        check1("rst_dvalid", dvalid, 1'b0);
        check1("rst_err", err, 1'b0);
        check32("rst_irdata", irdata, 32'h0);
        check32("rst_memaddr", maddr, 32'h0);
        rstn = 1;

        // single fetch
        step();
        ireq = 1; iaddr = 32'h10;
        step();
        check1("fetch_memreq", mreq, 1'b1);
        check32("fetch_addr", maddr, 32'h10);
        check1("fetch_we", mwe, 1'b0);
        check32("fetch_f3", {29'b0, mf3}, 32'h2);
        ireq = 0; ready = 1; mrdata = 32'h00500093;
        step();
        check1("fetch_ivalid", ivalid, 1'b1);
        check32("fetch_rdata", irdata, 32'h00500093);
        check1("fetch_err", err, 1'b0);
        check1("fetch_memreq_done", mreq, 1'b0);
        check32("model_irdata", m_irdata, 32'h00500093);
        ready = 0;
        step();
        check1("fetch_ivalid_off", ivalid, 1'b0);
        check32("fetch_rdata_hold", irdata, 32'h00500093);

        // conflict fairness after reset: D, I, D, I
        rstn = 0;
        step();
        rstn = 1;
        ireq = 1; dreq = 1; iaddr = 32'h200; daddr = 32'h300; dwe = 0; df3 = 3'b010;
        ready = 1; mrdata = 32'hCAFE0001;
        for (int k = 0; k < 4; k++) begin
            step();
            check32("fair_grant", maddr, (k % 2 == 0) ? 32'h300 : 32'h200);
            step();
            check1("fair_dvalid", dvalid, k % 2 == 0);
            check1("fair_ivalid", ivalid, k % 2 == 1);
            step();
        end
        ireq = 0; dreq = 0; ready = 0;
        check32("fair_drdata", drdata, 32'hCAFE0001);
        check1("model_last_d", m_last_d, 1'b0);

        // store with four wait cycles
        mrdata = 32'h12345678;
        dreq = 1; dwe = 1; daddr = 32'h100; dwdata = 32'hDEADBEEF; df3 = 3'b010;
        for (int w = 0; w < 5; w++) begin
            step();
            check1("st_memreq", mreq, 1'b1);
            check1("st_we", mwe, 1'b1);
            check32("st_addr", maddr, 32'h100);
            check32("st_wdata", mwdata, 32'hDEADBEEF);
            check32("st_f3", {29'b0, mf3}, 32'h2);
            if (w == 0) dreq = 0;
            if (w == 4) ready = 1;
        end
        step();
        check1("st_dvalid", dvalid, 1'b1);
        check1("st_err", err, 1'b0);
        check32("st_drdata_kept", drdata, 32'hCAFE0001);
        ready = 0; dwe = 0;
        step();

        // reset in the second GNT_D cycle
        dreq = 1; daddr = 32'h44;
        step();
        step();
        check1("mid_memreq_pre", mreq, 1'b1);
        rstn = 0; dreq = 0;
        step();
        check1("mid_memreq", mreq, 1'b0);
        check32("mid_state", 32'(dut.state), 32'(IDLE));
        rstn = 1;
        for (int c = 0; c < 6; c++) begin
            step();
            check1("mid_no_dvalid", dvalid, 1'b0);
        end

        // timeout with TIMEOUT=4, preceded by a good load to prove the zeroing
        t_dreq = 1; t_daddr = 32'h40; t_ready = 1; t_rdata = 32'hA5A5A5A5;
        step();
        t_dreq = 0;
        step();
        check1("to_pre_dvalid", t_dvalid, 1'b1);
        check32("to_pre_drdata", t_drdata, 32'hA5A5A5A5);
        step();
        t_dreq = 1; t_ready = 0; t_rdata = 32'hFFFFFFFF;
        for (int g = 0; g < TO_T; g++) begin
            step();
            check1("to_memreq", t_mreq, 1'b1);
            t_dreq = 0;
        end
        step();
        check1("to_memreq_drop", t_mreq, 1'b0);
        check1("to_dvalid", t_dvalid, 1'b1);
        check1("to_err", t_err, 1'b1);
        check32("to_drdata", t_drdata, 32'h0);
        step();

        // randomized traffic against the model
        i_pend = 0; d_pend = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (!rstn) begin
                rstn = 1; ireq = 0; dreq = 0; i_pend = 0; d_pend = 0;
            end
            if (m_done && !m_done_d) begin ireq = 0; i_pend = 0; end
            if (m_done && m_done_d)  begin dreq = 0; d_pend = 0; end
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                ireq = 1; iaddr = $urandom; i_pend = 1;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                dreq = 1; daddr = $urandom; dwdata = $urandom;
                dwe = 1'($urandom_range(0, 1)); df3 = 3'($urandom_range(0, 7));
                d_pend = 1;
            end
            ready  = ($urandom_range(0, 99) < 45);
            mrdata = $urandom;
            if ($urandom_range(0, 599) == 0) rstn = 0;
        end
        rstn = 1; ireq = 0; dreq = 0; ready = 0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: data and address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255: maximum grant cycles without iMemReady; range 1..255.
REQ-003 The block SHALL have port iClk, input, 1: the single clock. All state changes on its rising edge.
REQ-004 The block SHALL have port iRstN, input, 1: reset, synchronous, active-low.
REQ-005 The block SHALL have port iIReq, input, 1: instruction-fetch request.
REQ-006 The block SHALL have port iIAddr, input, DATA_W: fetch address.
REQ-007 The block SHALL have port oIValid, input/output direction output, 1: fetch complete pulse.
REQ-008 The block SHALL have port oIRdata, output, DATA_W: fetched instruction.
REQ-009 The block SHALL have ports iDReq (input, 1), iDWe (input, 1), iDAddr (input, DATA_W), iDWdata (input, DATA_W) and iDFunct3 (input, 3): load/store request, write enable, address, store data and access size.
REQ-010 The block SHALL have ports oDValid (output, 1) and oDRdata (output, DATA_W): load/store completion pulse and load data.
REQ-011 The block SHALL have port oErr, output, 1: completion was a timeout; valid only with oIValid or oDValid.
REQ-012 The block SHALL have ports oMemReq (output, 1), oMemWe (output, 1), oMemAddr (output, DATA_W), oMemWdata (output, DATA_W) and oMemFunct3 (output, 3): shared single-port memory request.
REQ-013 The block SHALL have ports iMemReady (input, 1) and iMemRdata (input, DATA_W): memory access done and read data, sampled in the same cycle.

Function
REQ-014 FSM states SHALL be IDLE, GNT_I, GNT_D and DONE.
REQ-015 In IDLE with only one request high, the FSM SHALL enter GNT_I or GNT_D next cycle.
REQ-016 In IDLE with both iIReq and iDReq high, the FSM SHALL grant D unless the last grant was D, then grant I.
  - This is round-robin on conflict; the last-grant flag updates on every grant.
REQ-017 On entering a GNT state, the request fields SHALL be captured into registers.
  - oMemAddr, oMemWe, oMemWdata and oMemFunct3 SHALL hold stable for the whole grant.
  - For I grants, oMemWe=0 and oMemFunct3=3'b010 (word).
REQ-018 oMemReq SHALL be 1 exactly while in GNT_I or GNT_D, and 0 otherwise.
REQ-019 In a GNT state with iMemReady=1, the FSM SHALL capture iMemRdata and enter DONE next cycle.
REQ-020 In DONE, the matching oIValid or oDValid SHALL be 1 for exactly one cycle, with oErr=0.
  - oIRdata and oDRdata SHALL hold the captured data until the next completion of that port.
  - A store SHALL return oDRdata unchanged.
REQ-021 DONE SHALL ignore all requests and return to IDLE.
  - A requester SHALL drop its request in the cycle after its valid unless it is issuing a new one.
REQ-022 Minimum latency SHALL be 3 cycles from request seen in IDLE to valid, with iMemReady high in the first grant cycle; each wait cycle adds 1.
REQ-023 An 8-bit wait counter SHALL clear on grant entry and increment each GNT cycle with iMemReady=0.
  - When it reaches TIMEOUT, the FSM SHALL enter DONE with oErr=1 and rdata forced to 0.
REQ-024 iMemReady outside GNT states SHALL be ignored.
REQ-025 Requests arriving during GNT or DONE SHALL wait; none SHALL be lost while held high.

Reset
REQ-026 While iRstN=0 at a rising edge, the block SHALL go to IDLE and clear these to 0:
  - all outputs, the capture registers, the wait counter and the last-grant flag (last grant = I).
REQ-027 Reset mid-grant SHALL abandon the transaction with no valid pulse; oMemReq SHALL be 0 in the first cycle after the reset edge.

Structure
REQ-028 A shared package mem_arb_pkg SHALL hold:
  - the state encoding (2-bit IDLE=0, GNT_I=1, GNT_D=2, DONE=3);
  - the funct3 width constant;
  - the word funct3 value 3'b010.
REQ-029 The timeout counter SHALL be a sub-module mem_arb_timer, with ports for clear, enable, TIMEOUT compare and expired.

Verification
REQ-030 Single fetch: iIReq=1, iIAddr=0x10 in IDLE, iMemReady=1 at first grant, iMemRdata=0x00500093 -> oMemReq for 1 cycle with oMemAddr=0x10 and oMemWe=0; oIValid 3 cycles after the request with oIRdata=0x00500093.
REQ-031 Conflict fairness: iIReq and iDReq held high, ready always 1 -> grants alternate D, I, D, I; each transaction is 3 cycles; the grant after reset is D.
REQ-032 Store: iDReq=1, iDWe=1, iDAddr=0x100, iDWdata=0xDEADBEEF, iDFunct3=3'b010, iMemReady after 4 wait cycles -> oMemWe=1 with stable fields for 5 cycles; oDValid 7 cycles after the request; oErr=0.
REQ-033 Timeout: TIMEOUT=4 and iMemReady held 0 -> oMemReq drops after 4 grant cycles; oDValid=1 with oErr=1 and oDRdata=0.
REQ-034 Reset mid-grant: iRstN=0 in the second GNT_D cycle -> next cycle oMemReq=0 and the state is IDLE; no valid pulse ever appears for that transaction.
